// File: rtl/cordic_arbiter_pkg.sv
// cordic_arbiter_pkg: shared widths, IDs, FSM states and parameter defaults
// for the two-requester CORDIC arbiter and its tag FIFO.
package cordic_arbiter_pkg;

   localparam int OPW           = 18;   // signed rectangular operand width
   localparam int RESW          = 23;   // magnitude / phase result width
   localparam int LATENCY_DEF   = 24;   // core cycles from cor_nd to cor_rdy
   localparam int TAG_DEPTH_DEF = 32;   // tag FIFO depth, at least LATENCY+2

   // Requester identifier carried through the tag FIFO
   typedef logic [0:0] req_id_t;

   // DRAIN flushes results left in the core after reset; RUN arbitrates
   typedef enum logic [0:0] {
      ST_DRAIN = 1'b0,
      ST_RUN   = 1'b1
   } arb_state_t;

endpackage

// File: rtl/cordic_tag_fifo.sv
// cordic_tag_fifo: circular FIFO of requester IDs, one entry per operand in
// flight through the core. Push when full and pop when empty are ignored.
module cordic_tag_fifo
   import cordic_arbiter_pkg::*;
#(
   parameter int DEPTH = TAG_DEPTH_DEF
) (
   input  logic    clk,
   input  logic    reset_n,
   input  logic    push,
   input  logic    pop,
   input  req_id_t din,
   output req_id_t dout,
   output logic    full,
   output logic    empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   req_id_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == {CW{1'b0}});
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap modulo DEPTH; occupancy tracks push/pop, unchanged on both
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= {PW{1'b0}};
         rd_ptr <= {PW{1'b0}};
         count  <= {CW{1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? {PW{1'b0}} : wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? {PW{1'b0}} : rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Tag storage, cleared on reset so dout is never undefined
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 1'b0;
         end
      end else if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one pipelined CORDIC core between two requesters,
// tagging each issued operand so results return to the right requester in
// issue order. Build macro CORDIC_ARB_PRIO_EN gives req0 strict priority;
// without it arbitration is round-robin.
module cordic_arbiter
   import cordic_arbiter_pkg::*;
#(
   parameter int LATENCY   = LATENCY_DEF,
   parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req0_valid,
   input  logic [OPW-1:0]  req0_x,
   input  logic [OPW-1:0]  req0_y,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [OPW-1:0]  req1_x,
   input  logic [OPW-1:0]  req1_y,
   output logic            req1_ready,
   output logic [OPW-1:0]  cor_x_in,
   output logic [OPW-1:0]  cor_y_in,
   output logic            cor_nd,
   input  logic [RESW-1:0] cor_x_out,
   input  logic [RESW-1:0] cor_phase_out,
   input  logic            cor_rdy,
   output logic            res0_valid,
   output logic            res1_valid,
   output logic [RESW-1:0] res_mag,
   output logic [RESW-1:0] res_phase,
   output logic            busy,
   output logic            err
);

   localparam int DCW = $clog2(LATENCY + 2) + 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LATENCY + 1);

   arb_state_t     state;
   arb_state_t     state_nxt;
   logic [DCW-1:0] drain_cnt;
   logic           run;
   logic           grant0;
   logic           grant1;
   logic           push;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   req_id_t        head_tag;
`ifdef CORDIC_ARB_PRIO_EN
   // strict priority needs no arbitration history
`else
   logic           rr_last;   // 1: req1 granted last, so req0 wins next tie
`endif

   assign run        = (state == ST_RUN);
   assign push       = grant0 || grant1;
   assign pop        = run && cor_rdy && !fifo_empty;
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign busy       = (state == ST_DRAIN) || !fifo_empty;

   cordic_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (grant1),
      .dout    (head_tag),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // State register and drain timer: DRAIN lasts LATENCY+2 cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_DRAIN;
         drain_cnt <= {DCW{1'b0}};
      end else begin
         state <= state_nxt;
         if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + DCW'(1);
         end else begin
            drain_cnt <= {DCW{1'b0}};
         end
      end
   end

   // Next state and combinational grant, gated by RUN and tag FIFO space
   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      case (state)
         ST_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_RUN: begin
            state_nxt = ST_RUN;
            if (!fifo_full) begin
`ifdef CORDIC_ARB_PRIO_EN
               grant0 = req0_valid;
               grant1 = req1_valid && !req0_valid;
`else
               if (req0_valid && req1_valid) begin
                  grant0 = rr_last;
                  grant1 = !rr_last;
               end else begin
                  grant0 = req0_valid;
                  grant1 = req1_valid;
               end
`endif
            end else begin
               grant0 = 1'b0;
               grant1 = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_DRAIN;
         end
      endcase
   end

`ifdef CORDIC_ARB_PRIO_EN
`else
   // Round-robin history: remember who won so the other wins the next tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_last <= 1'b1;
      end else if (grant0) begin
         rr_last <= 1'b0;
      end else if (grant1) begin
         rr_last <= 1'b1;
      end else begin
         rr_last <= rr_last;
      end
   end
`endif

   // Issue side: register the granted operand and strobe cor_nd for one cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cor_nd   <= 1'b0;
         cor_x_in <= {OPW{1'b0}};
         cor_y_in <= {OPW{1'b0}};
      end else begin
         cor_nd <= push;
         if (grant1) begin
            cor_x_in <= req1_x;
            cor_y_in <= req1_y;
         end else if (grant0) begin
            cor_x_in <= req0_x;
            cor_y_in <= req0_y;
         end else begin
            cor_x_in <= cor_x_in;
            cor_y_in <= cor_y_in;
         end
      end
   end

   // Return side: route core results by head tag; orphan results raise err
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res0_valid <= 1'b0;
         res1_valid <= 1'b0;
         res_mag    <= {RESW{1'b0}};
         res_phase  <= {RESW{1'b0}};
         err        <= 1'b0;
      end else begin
         res0_valid <= pop && (head_tag == 1'b0);
         res1_valid <= pop && (head_tag == 1'b1);
         if (pop) begin
            res_mag   <= cor_x_out;
            res_phase <= cor_phase_out;
         end
         if (run && cor_rdy && fifo_empty) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: randomized and directed stimulus, a behavioural core
// model (mag = x+y, phase = x-y after LATENCY cycles) and a scoreboard.
module tb_cordic_arbiter;
   import cordic_arbiter_pkg::*;

   localparam int LAT   = LATENCY_DEF;
   localparam int DEPTH = TAG_DEPTH_DEF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_valid, req1_valid;
   logic [17:0] req0_x, req0_y, req1_x, req1_y;
   logic        req0_ready, req1_ready;
   logic [17:0] cor_x_in, cor_y_in;
   logic        cor_nd;
   logic [22:0] cor_x_out, cor_phase_out;
   logic        cor_rdy;
   logic        res0_valid, res1_valid;
   logic [22:0] res_mag, res_phase;
   logic        busy, err;

   always #5 clk = ~clk;

   cordic_arbiter dut (
      .clk (clk), .reset_n (reset_n),
      .req0_valid (req0_valid), .req0_x (req0_x), .req0_y (req0_y), .req0_ready (req0_ready),
      .req1_valid (req1_valid), .req1_x (req1_x), .req1_y (req1_y), .req1_ready (req1_ready),
      .cor_x_in (cor_x_in), .cor_y_in (cor_y_in), .cor_nd (cor_nd),
      .cor_x_out (cor_x_out), .cor_phase_out (cor_phase_out), .cor_rdy (cor_rdy),
      .res0_valid (res0_valid), .res1_valid (res1_valid),
      .res_mag (res_mag), .res_phase (res_phase), .busy (busy), .err (err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [22:0] ref_mag(input logic [17:0] x, input logic [17:0] y);
      int s;
      s = int'($signed(x)) + int'($signed(y));
      return s[22:0];
   endfunction

   function automatic logic [22:0] ref_ph(input logic [17:0] x, input logic [17:0] y);
      int s;
      s = int'($signed(x)) - int'($signed(y));
      return s[22:0];
   endfunction

   // ---------------- behavioural core model ----------------
   typedef struct { int due; logic [22:0] mag; logic [22:0] ph; } core_item_t;
   core_item_t core_q[$];
   int ccyc      = 0;
   bit stall     = 1'b0;
   bit pulse_one = 1'b0;
   bit force_rdy = 1'b0;

   initial begin
      cor_rdy = 1'b0; cor_x_out = '0; cor_phase_out = '0;
      forever begin
         @(negedge clk);
         ccyc++;
         if (cor_nd === 1'b1)
            core_q.push_back('{ccyc + LAT, ref_mag(cor_x_in, cor_y_in), ref_ph(cor_x_in, cor_y_in)});
         cor_rdy = 1'b0;
         if (force_rdy) begin
            cor_rdy = 1'b1; cor_x_out = 23'h001234; cor_phase_out = 23'h000777;
         end else if (core_q.size() > 0 && core_q[0].due <= ccyc && (!stall || pulse_one)) begin
            cor_rdy = 1'b1;
            cor_x_out = core_q[0].mag;
            cor_phase_out = core_q[0].ph;
            void'(core_q.pop_front());
            pulse_one = 1'b0;
         end
      end
   end

   // ---------------- arbiter reference model ----------------
   typedef struct { bit id; logic [22:0] mag; logic [22:0] ph; int acc; } exp_t;
   exp_t exp_q[$];
   int          cyc = 0;
   int          m_cnt = 0;       // cycles since reset release (saturating)
   int          m_out = 0;       // tags outstanding
   bit          m_last = 1'b1;   // requester granted last
   bit          m_err = 1'b0;
   int          m_acc_cyc = -10;
   logic [17:0] m_xin = '0, m_yin = '0;
   bit          stall_used = 1'b0;
   int          acc_cnt = 0;

   function automatic void exp_grant(output bit g0, output bit g1);
      g0 = 1'b0; g1 = 1'b0;
      if (m_cnt >= LAT + 2 && m_out < DEPTH) begin
`ifdef CORDIC_ARB_PRIO_EN
         g0 = req0_valid;
         g1 = req1_valid && !req0_valid;
`else
         if (req0_valid && req1_valid) begin
            g0 = (m_last == 1'b1);
            g1 = (m_last == 1'b0);
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
`endif
      end
   endfunction

   // Advance the model at each clock edge from inputs only
   always @(posedge clk or negedge reset_n) begin
      bit g0, g1, run, pop_ok;
      logic [17:0] x, y;
      cyc++;
      if (!reset_n) begin
         m_cnt = 0; m_out = 0; m_last = 1'b1; m_err = 1'b0;
         m_acc_cyc = -10; m_xin = '0; m_yin = '0;
         exp_q.delete();
      end else begin
         exp_grant(g0, g1);
         run    = (m_cnt >= LAT + 2);
         pop_ok = run && cor_rdy && (m_out > 0);
         if (run && cor_rdy && m_out == 0) m_err = 1'b1;
         if (g0 || g1) begin
            x = g1 ? req1_x : req0_x;
            y = g1 ? req1_y : req0_y;
            exp_q.push_back('{g1, ref_mag(x, y), ref_ph(x, y), cyc});
            m_last = g1; m_xin = x; m_yin = y; m_acc_cyc = cyc;
         end
         m_out = m_out + ((g0 || g1) ? 1 : 0) - (pop_ok ? 1 : 0);
         if (m_cnt < LAT + 2) m_cnt++;
      end
   end

   // Monitor: compare DUT outputs with the model away from the active edge
   always @(negedge clk) begin
      bit g0, g1;
      exp_t e;
      if (reset_n) begin
         exp_grant(g0, g1);
         check("req0_ready", req0_ready, g0);
         check("req1_ready", req1_ready, g1);
         if (req0_valid && req0_ready) acc_cnt++;
         if (req1_valid && req1_ready) acc_cnt++;
         check("busy", busy, (m_cnt < LAT + 2) || (m_out > 0));
         check("err", err, m_err);
         check("cor_nd", cor_nd, m_acc_cyc == cyc);
         check("cor_x_in", cor_x_in, m_xin);
         check("cor_y_in", cor_y_in, m_yin);
         check("res_onehot", res0_valid && res1_valid, 0);
         if (res0_valid || res1_valid) begin
            if (exp_q.size() == 0) begin
               check("res_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("res_tag", res1_valid, e.id);
               check("res_mag", res_mag, e.mag);
               check("res_phase", res_phase, e.ph);
               if (!stall_used) check("res_latency", cyc - e.acc, LAT + 1);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit v0, input bit v1);
      req0_valid = v0; req1_valid = v1;
      req0_x = 18'($urandom); req0_y = 18'($urandom);
      req1_x = 18'($urandom); req1_y = 18'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, a0;
      bit seen;
      reset_n = 1'b0;
      drive(1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      // Reset release: ready held low through DRAIN while req0 waits
      req0_valid = 1'b1; req0_x = 18'd65536; req0_y = 18'd65536;
      reset_n = 1'b1;
      n = 0;
      while (req0_ready !== 1'b1 && n < 40) begin tick(); n++; end
      check("drain_cycles", n, LAT + 2);
      // Single accept of (65536,65536)
      tick();
      check("dir_cor_nd", cor_nd, 1);
      check("dir_cor_x_in", cor_x_in, 65536);
      req0_valid = 1'b0;
      k = 1; seen = 1'b0;
      while (!seen && k < 40) begin
         tick(); k++;
         check("dir_res1_quiet", res1_valid, 0);
         if (res0_valid) begin
            seen = 1'b1;
            check("dir_latency", k, LAT + 2);
            check("dir_mag", res_mag, 131072);
            check("dir_phase", res_phase, 0);
         end
      end
      check("dir_res_seen", seen, 1);
      repeat (3) tick();

      // Contention: both valid for 10 cycles
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1);
         #1;
`ifdef CORDIC_ARB_PRIO_EN
         check("prio_r0", req0_ready, 1);
         check("prio_r1", req1_ready, 0);
`else
         check("alt_r1", req1_ready, (i % 2 == 0));
         check("alt_r0", req0_ready, (i % 2 == 1));
`endif
         tick();
      end
`ifdef CORDIC_ARB_PRIO_EN
      drive(1'b0, 1'b1);
      #1;
      check("prio_r1_after_drop", req1_ready, 1);
      tick();
`endif
      drive(1'b0, 1'b0);
      repeat (40) tick();

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
         tick();
      end
      drive(1'b0, 1'b0);
      repeat (40) tick();
      check("random_drained", exp_q.size(), 0);

      // Orphan core result with nothing outstanding: sticky err
      force_rdy = 1'b1;
      tick();
      force_rdy = 1'b0;
      repeat (6) tick();
      check("err_sticky", err, 1);

      // Reset mid-operation: in-flight results fall into DRAIN
      for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1); tick(); end
      drive(1'b0, 1'b0);
      reset_n = 1'b0;
      tick(); tick();
      check("reset_err_clear", err, 0);
      reset_n = 1'b1;
      repeat (60) tick();
      check("reset_no_err", err, 0);
      check("reset_core_flushed", core_q.size(), 0);

      // Core stall: 32 issues fill the tag FIFO
      stall_used = 1'b1;
      stall = 1'b1;
      a0 = acc_cnt;
      for (int i = 0; i < 40; i++) begin drive(1'b1, 1'b1); tick(); end
      check("stall_accepts", acc_cnt - a0, DEPTH);
      check("stall_r0_low", req0_ready, 0);
      check("stall_r1_low", req1_ready, 0);
      a0 = acc_cnt;
      pulse_one = 1'b1;
      for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b1); tick(); end
      check("one_pulse_one_grant", acc_cnt - a0, 1);
      drive(1'b0, 1'b0);
      stall = 1'b0;
      repeat (100) tick();
      check("stall_drained", exp_q.size(), 0);
      check("final_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
